// File: rtl/common_types_pkg.sv
// common_types_pkg: shared AHB transfer encodings, data-phase owner type and address-phase bundle
package common_types_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  typedef enum logic [1:0] {OWNER_NONE, OWNER_M0, OWNER_M1} owner_t;
  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
  } addr_phase_t;
  function automatic logic is_xfer(input logic [1:0] t);
    return t == HTRANS_NONSEQ || t == HTRANS_SEQ;
  endfunction
endpackage

// File: rtl/ahb_arb_input_stage.sv
// ahb_arb_input_stage: one-deep pending address-phase holder for a manager that lost arbitration
// Ports: clk/nrst; live = manager's current address phase; capture loads it, issue retires it;
// pend/valid = queued address phase and its valid flag.
module ahb_arb_input_stage
  import common_types_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  addr_phase_t live,
  input  logic        capture,
  input  logic        issue,
  output addr_phase_t pend,
  output logic        valid
);
  addr_phase_t pend_d, pend_q;
  logic valid_d, valid_q;
  always_comb begin
    valid_d = capture | (valid_q & ~issue);
    pend_d  = capture ? live : pend_q;
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      valid_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end
  assign pend  = pend_q;
  assign valid = valid_q;
endmodule

// File: rtl/ahb_manager_arbiter.sv
// ahb_manager_arbiter: two-manager (core m0, DMA m1) round-robin AHB arbiter with burst lock
// Ports: m0_*/m1_* manager-side address/data inputs and hready/hrdata/hresp outputs;
// bus-side haddr/htrans/hwrite/hsize/hburst/hwdata outputs and hready/hrdata/hresp inputs.
module ahb_manager_arbiter
  import common_types_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] m0_haddr,
  input  logic [1:0]  m0_htrans,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [2:0]  m0_hburst,
  input  logic [31:0] m0_hwdata,
  output logic        m0_hready,
  output logic [31:0] m0_hrdata,
  output logic        m0_hresp,
  input  logic [31:0] m1_haddr,
  input  logic [1:0]  m1_htrans,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [2:0]  m1_hburst,
  input  logic [31:0] m1_hwdata,
  output logic        m1_hready,
  output logic [31:0] m1_hrdata,
  output logic        m1_hresp,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [31:0] hrdata,
  input  logic        hresp
);
  addr_phase_t a0, a1, p0, p1, e0, e1, bus;
  owner_t owner_d, owner_q, own;
  logic last_d, last_q;
  logic v0, v1, pv0, pv1, act0, act1, req0, req1, lock0, lock1, gnt0, gnt1;
  logic cap0, cap1, iss0, iss1;

  ahb_arb_input_stage u_stage0 (
    .clk(clk), .nrst(nrst), .live(a0), .capture(cap0), .issue(iss0), .pend(p0), .valid(v0)
  );
  ahb_arb_input_stage u_stage1 (
    .clk(clk), .nrst(nrst), .live(a1), .capture(cap1), .issue(iss1), .pend(p1), .valid(v1)
  );

  always_comb begin
    // Gating state with nrst keeps every output at its idle value while reset is held.
    pv0 = nrst & v0;
    pv1 = nrst & v1;
    own = nrst ? owner_q : OWNER_NONE;
    m0_hready = ~pv0 & (own == OWNER_M0 ? hready : 1'b1);
    m1_hready = ~pv1 & (own == OWNER_M1 ? hready : 1'b1);
    a0 = '{m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hburst};
    a1 = '{m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hburst};
    act0 = nrst & m0_hready & is_xfer(m0_htrans);
    act1 = nrst & m1_hready & is_xfer(m1_htrans);
    e0 = pv0 ? p0 : a0;
    e1 = pv1 ? p1 : a1;
    req0 = pv0 | act0;
    req1 = pv1 | act1;
    // The last-granted manager continuing with SEQ keeps the bus for the rest of its burst.
    lock0 = req0 & ~last_q & (e0.htrans == HTRANS_SEQ);
    lock1 = req1 & last_q & (e1.htrans == HTRANS_SEQ);
    gnt0 = hready & req0 & (lock0 | (~lock1 & (~req1 | last_q)));
    gnt1 = hready & req1 & (lock1 | (~lock0 & (~req0 | ~last_q)));
    cap0 = act0 & ~gnt0;
    cap1 = act1 & ~gnt1;
    iss0 = gnt0 & pv0;
    iss1 = gnt1 & pv1;
    bus = gnt0 ? e0 : gnt1 ? e1 : '0;
    haddr  = bus.haddr;
    htrans = bus.htrans;
    hwrite = bus.hwrite;
    hsize  = bus.hsize;
    hburst = bus.hburst;
    hwdata = own == OWNER_M0 ? m0_hwdata : own == OWNER_M1 ? m1_hwdata : '0;
    m0_hrdata = hrdata;
    m1_hrdata = hrdata;
    m0_hresp = (own == OWNER_M0) & hresp;
    m1_hresp = (own == OWNER_M1) & hresp;
    last_d  = gnt0 ? 1'b0 : gnt1 ? 1'b1 : last_q;
    owner_d = !hready ? owner_q : gnt0 ? OWNER_M0 : gnt1 ? OWNER_M1 : OWNER_NONE;
  end

  // last_q = 1 means m1 was granted last, so m0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      last_q  <= 1'b1;
      owner_q <= OWNER_NONE;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end
endmodule
